demux_scheduler: RTL and testbench

- Sequences the 1:4 demultiplexer datapath. Accepts single words from one upstream valid/ready source and steers each word to one of four downstream channels.
- The target channel comes either from a round-robin pointer or from an explicit destination field.
- Drives the shared output data bus and the 2-bit channel select ({s1,s0} of the demux). Per-channel valid is the demux of the internal valid.
- Handles disabled channels and stalled consumers; keeps dispatch and drop counters.

---
 rtl/demux_scheduler.sv | 136 +++++++++++++
 tb/tb_demux_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_scheduler.sv
// demux_scheduler: steers single upstream words onto one of four downstream
// channels (round-robin or addressed) through a shared data bus and a 2-bit
// channel select, with a per-word hold timeout and dispatch/drop counters.
module demux_scheduler #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_dest,
   input  logic             mode,
   input  logic [3:0]       chan_en,
   output logic [3:0]       out_valid,
   input  logic [3:0]       out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       sel,
   output logic             busy,
   output logic [CNT_W-1:0] dispatch_cnt,
   output logic [CNT_W-1:0] drop_cnt
);

   // Timer only needs to reach TIMEOUT-1; a zero TIMEOUT disables the check.
   localparam int unsigned   TMR_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam bit            TMO_EN   = (TIMEOUT != 0);
   localparam logic [TMR_W-1:0] TMR_LAST = TMO_EN ? TMR_W'(TIMEOUT - 1) : '0;

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t             state_q;
   logic [1:0]         sel_q;
   logic [1:0]         rr_ptr_q;
   logic [TMR_W-1:0]   timer_q;
   logic [WIDTH-1:0]   out_data_q;
   logic [3:0]         out_valid_q;
   logic               busy_q;
   logic [CNT_W-1:0]   dispatch_q;
   logic [CNT_W-1:0]   drop_q;

   logic [1:0]         rr_tgt_c;
   logic [1:0]         tgt_c;
   logic               in_ready_c;
   logic               accept_c;
   logic               idle_drop_c;
   logic               xfer_c;
   logic               tmo_c;

   function automatic logic [3:0] onehot(input logic [1:0] s);
      return 4'b0001 << s;
   endfunction

   // First enabled channel at or after rr_ptr (lowest offset wins).
   always_comb begin
      rr_tgt_c = rr_ptr_q;
      for (int i = 3; i >= 0; i--) begin
         if (chan_en[rr_ptr_q + 2'(i)]) begin
            rr_tgt_c = rr_ptr_q + 2'(i);
         end
      end
   end

   // Handshake and decision terms for the current cycle.
   always_comb begin
      in_ready_c  = (state_q == IDLE) && !(!mode && (chan_en == 4'b0000));
      accept_c    = in_valid && in_ready_c;
      tgt_c       = mode ? in_dest : rr_tgt_c;
      idle_drop_c = mode && !chan_en[in_dest];
      xfer_c      = out_ready[sel_q];
      tmo_c       = TMO_EN && (timer_q == TMR_LAST);
   end

   // Scheduler FSM with registered channel valid, select, data and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= 2'd0;
         rr_ptr_q    <= 2'd0;
         timer_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 4'b0000;
         busy_q      <= 1'b0;
         dispatch_q  <= '0;
         drop_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_c) begin
                  if (idle_drop_c) begin
                     drop_q <= drop_q + CNT_W'(1);
                  end else begin
                     out_data_q  <= in_data;
                     sel_q       <= tgt_c;
                     timer_q     <= '0;
                     out_valid_q <= onehot(tgt_c);
                     busy_q      <= 1'b1;
                     state_q     <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (xfer_c) begin
                  dispatch_q  <= dispatch_q + CNT_W'(1);
                  rr_ptr_q    <= sel_q + 2'd1;
                  out_valid_q <= 4'b0000;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end else if (tmo_c) begin
                  drop_q      <= drop_q + CNT_W'(1);
                  rr_ptr_q    <= sel_q + 2'd1;
                  out_valid_q <= 4'b0000;
                  busy_q      <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  timer_q <= timer_q + TMR_W'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready     = in_ready_c;
   assign out_valid    = out_valid_q;
   assign out_data     = out_data_q;
   assign sel          = sel_q;
   assign busy         = busy_q;
   assign dispatch_cnt = dispatch_q;
   assign drop_cnt     = drop_q;

endmodule

// File: tb/tb_demux_scheduler.sv
// Bench for demux_scheduler: directed vector table, hand-written corner
// sequences (timeout, held-word stability, async reset) and a random run
// against a word-level reference model.
module tb_demux_scheduler;

   localparam int unsigned WIDTH   = 8;
   localparam int unsigned CNT_W   = 8;
   localparam int unsigned TIMEOUT = 16;
   localparam int          TMO_I   = 16;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [1:0]       in_dest;
   logic             mode;
   logic [3:0]       chan_en;
   logic [3:0]       out_valid;
   logic [3:0]       out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       sel;
   logic             busy;
   logic [CNT_W-1:0] dispatch_cnt;
   logic [CNT_W-1:0] drop_cnt;

   int n_checks = 0;
   int n_err    = 0;

   demux_scheduler #(.WIDTH(WIDTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_dest(in_dest), .mode(mode), .chan_en(chan_en),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .sel(sel), .busy(busy),
      .dispatch_cnt(dispatch_cnt), .drop_cnt(drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [7:0] d, input logic [1:0] dst,
                        input logic md, input logic [3:0] en, input logic [3:0] ordy);
      in_valid  = iv;
      in_data   = d;
      in_dest   = dst;
      mode      = md;
      chan_en   = en;
      out_ready = ordy;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic       iv;
      logic [7:0] d;
      logic [1:0] dst;
      logic       md;
      logic [3:0] en;
      logic [3:0] ordy;
      logic       e_rdy;
      logic [3:0] e_ov;
      logic [1:0] e_sel;
      logic [7:0] e_data;
      int         e_disp;
      int         e_drop;
   } vec_t;

   function automatic vec_t mk(input logic iv, input logic [7:0] d, input logic [1:0] dst,
                               input logic md, input logic [3:0] en, input logic [3:0] ordy,
                               input logic e_rdy, input logic [3:0] e_ov, input logic [1:0] e_sel,
                               input logic [7:0] e_data, input int e_disp, input int e_drop);
      vec_t v;
      v.iv = iv; v.d = d; v.dst = dst; v.md = md; v.en = en; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_sel = e_sel; v.e_data = e_data;
      v.e_disp = e_disp; v.e_drop = e_drop;
      return v;
   endfunction

   localparam int NV = 18;
   vec_t tbl [NV];

   // ---------------- word-level reference model ----------------
   bit m_held;
   int m_ch, m_sel, m_data, m_wait, m_rr, m_disp, m_drop;

   task automatic model_reset();
      m_held = 0; m_ch = 0; m_sel = 0; m_data = 0; m_wait = 0;
      m_rr = 0; m_disp = 0; m_drop = 0;
   endtask

   function automatic bit m_rdy();
      return !m_held && !(mode == 1'b0 && chan_en == 4'b0000);
   endfunction

   // Advance the model by one clock edge using the currently driven inputs.
   task automatic model_step();
      int t;
      if (m_held) begin
         if (out_ready[m_ch]) begin
            m_disp++;
            m_rr   = (m_ch + 1) % 4;
            m_held = 0;
         end else begin
            m_wait++;
            if (TMO_I != 0 && m_wait == TMO_I) begin
               m_drop++;
               m_rr   = (m_ch + 1) % 4;
               m_held = 0;
            end
         end
      end else if (in_valid && m_rdy()) begin
         t = -1;
         if (mode) begin
            if (chan_en[in_dest]) t = int'(in_dest);
         end else begin
            for (int k = 0; k < 4; k++)
               if (t < 0 && chan_en[(m_rr + k) % 4]) t = (m_rr + k) % 4;
         end
         if (t < 0) begin
            m_drop++;
         end else begin
            m_held = 1; m_ch = t; m_sel = t; m_data = int'(in_data); m_wait = 0;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [3:0] exp_ov;

      tbl[0]  = mk(1'b1, 8'hA0, 2'd0, 1'b0, 4'hF, 4'hF, 1'b1, 4'b0001, 2'd0, 8'hA0, 0, 0);
      tbl[1]  = mk(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'hF, 1'b0, 4'b0000, 2'd0, 8'hA0, 1, 0);
      tbl[2]  = mk(1'b1, 8'hA1, 2'd0, 1'b0, 4'hF, 4'hF, 1'b1, 4'b0010, 2'd1, 8'hA1, 1, 0);
      tbl[3]  = mk(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'hF, 1'b0, 4'b0000, 2'd1, 8'hA1, 2, 0);
      tbl[4]  = mk(1'b1, 8'hA2, 2'd0, 1'b0, 4'hF, 4'hF, 1'b1, 4'b0100, 2'd2, 8'hA2, 2, 0);
      tbl[5]  = mk(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'hF, 1'b0, 4'b0000, 2'd2, 8'hA2, 3, 0);
      tbl[6]  = mk(1'b1, 8'hA3, 2'd0, 1'b0, 4'hF, 4'hF, 1'b1, 4'b1000, 2'd3, 8'hA3, 3, 0);
      tbl[7]  = mk(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'hF, 1'b0, 4'b0000, 2'd3, 8'hA3, 4, 0);
      tbl[8]  = mk(1'b1, 8'hB0, 2'd0, 1'b0, 4'hA, 4'hF, 1'b1, 4'b0010, 2'd1, 8'hB0, 4, 0);
      tbl[9]  = mk(1'b0, 8'h00, 2'd0, 1'b0, 4'hA, 4'hF, 1'b0, 4'b0000, 2'd1, 8'hB0, 5, 0);
      tbl[10] = mk(1'b1, 8'hB1, 2'd0, 1'b0, 4'hA, 4'hF, 1'b1, 4'b1000, 2'd3, 8'hB1, 5, 0);
      tbl[11] = mk(1'b0, 8'h00, 2'd0, 1'b0, 4'hA, 4'hF, 1'b0, 4'b0000, 2'd3, 8'hB1, 6, 0);
      tbl[12] = mk(1'b1, 8'hB2, 2'd0, 1'b0, 4'hA, 4'hF, 1'b1, 4'b0010, 2'd1, 8'hB2, 6, 0);
      tbl[13] = mk(1'b0, 8'h00, 2'd0, 1'b0, 4'hA, 4'hF, 1'b0, 4'b0000, 2'd1, 8'hB2, 7, 0);
      tbl[14] = mk(1'b1, 8'hC0, 2'd0, 1'b0, 4'h0, 4'hF, 1'b0, 4'b0000, 2'd1, 8'hB2, 7, 0);
      tbl[15] = mk(1'b1, 8'hC1, 2'd0, 1'b0, 4'h0, 4'hF, 1'b0, 4'b0000, 2'd1, 8'hB2, 7, 0);
      tbl[16] = mk(1'b1, 8'h55, 2'd2, 1'b1, 4'hB, 4'hF, 1'b1, 4'b0000, 2'd1, 8'hB2, 7, 1);
      tbl[17] = mk(1'b0, 8'h00, 2'd2, 1'b1, 4'hB, 4'hF, 1'b1, 4'b0000, 2'd1, 8'hB2, 7, 1);

      // Reset state
      rst = 1'b1;
      drive(1'b0, 8'h00, 2'd0, 1'b0, 4'hF, 4'hF);
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_in_ready",  32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data), 32'd0);
      chk("rst_sel",       32'(sel), 32'd0);
      chk("rst_busy",      32'(busy), 32'd0);
      chk("rst_dispatch",  32'(dispatch_cnt), 32'd0);
      chk("rst_drop",      32'(drop_cnt), 32'd0);

      // Table: inputs for one cycle, in_ready before the edge, outputs after it
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].iv, tbl[i].d, tbl[i].dst, tbl[i].md, tbl[i].en, tbl[i].ordy);
         #1;
         chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
         tick();
         chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("v%0d_sel", i),       32'(sel), 32'(tbl[i].e_sel));
         chk($sformatf("v%0d_out_data", i),  32'(out_data), 32'(tbl[i].e_data));
         chk($sformatf("v%0d_busy", i),      32'(busy), 32'(tbl[i].e_ov != 4'b0000));
         chk($sformatf("v%0d_dispatch", i),  32'(dispatch_cnt), 32'(tbl[i].e_disp));
         chk($sformatf("v%0d_drop", i),      32'(drop_cnt), 32'(tbl[i].e_drop));
      end

      // Timeout: word held on channel 0 with no ready, visible 16 cycles
      drive(1'b1, 8'h77, 2'd0, 1'b1, 4'hF, 4'h0);
      tick();
      in_valid = 1'b0;
      n = 0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid != 4'b0001) break;
         n++;
         tick();
      end
      chk("tmo_valid_cycles", 32'(n), 32'd16);
      chk("tmo_out_valid",    32'(out_valid), 32'd0);
      chk("tmo_drop",         32'(drop_cnt), 32'd2);
      chk("tmo_dispatch",     32'(dispatch_cnt), 32'd7);
      drive(1'b1, 8'h88, 2'd0, 1'b0, 4'hF, 4'h0);
      tick();
      in_valid = 1'b0;
      chk("tmo_next_sel", 32'(sel), 32'd1);
      out_ready = 4'hF;
      tick();
      chk("tmo_next_dispatch", 32'(dispatch_cnt), 32'd8);

      // Held word on channel 3 ignores mode/chan_en changes and other readies
      drive(1'b1, 8'h3C, 2'd3, 1'b1, 4'hF, 4'h0);
      tick();
      in_valid = 1'b0;
      chk("h3_sel", 32'(sel), 32'd3);
      for (int k = 0; k < 5; k++) begin
         out_ready = 4'b0111;
         mode      = 1'($urandom_range(0, 1));
         chan_en   = 4'($urandom_range(0, 15));
         in_dest   = 2'($urandom_range(0, 3));
         tick();
         chk($sformatf("h3_ov_%0d", k),   32'(out_valid), 32'b1000);
         chk($sformatf("h3_data_%0d", k), 32'(out_data), 32'h3C);
         chk($sformatf("h3_disp_%0d", k), 32'(dispatch_cnt), 32'd8);
      end
      out_ready = 4'b1000;
      tick();
      chk("h3_xfer_dispatch", 32'(dispatch_cnt), 32'd9);
      chk("h3_xfer_ov",       32'(out_valid), 32'd0);
      chk("h3_xfer_data",     32'(out_data), 32'h3C);

      // Asynchronous reset in the middle of a HOLD
      drive(1'b1, 8'h99, 2'd2, 1'b1, 4'hF, 4'h0);
      tick();
      in_valid = 1'b0;
      chk("ar_pre_ov", 32'(out_valid), 32'b0100);
      #3;
      rst = 1'b1;
      #1;
      chk("ar_ov",       32'(out_valid), 32'd0);
      chk("ar_sel",      32'(sel), 32'd0);
      chk("ar_busy",     32'(busy), 32'd0);
      chk("ar_dispatch", 32'(dispatch_cnt), 32'd0);
      chk("ar_drop",     32'(drop_cnt), 32'd0);
      #2;
      rst = 1'b0;
      tick();
      drive(1'b1, 8'h11, 2'd0, 1'b0, 4'hF, 4'hF);
      tick();
      in_valid = 1'b0;
      chk("ar_next_sel", 32'(sel), 32'd0);
      chk("ar_next_ov",  32'(out_valid), 32'b0001);

      // Random run against the reference model
      rst = 1'b1;
      #2;
      rst = 1'b0;
      model_reset();
      tick();
      for (int c = 0; c < 3000; c++) begin
         in_valid  = 1'($urandom_range(0, 3) != 0);
         in_data   = 8'($urandom);
         in_dest   = 2'($urandom_range(0, 3));
         mode      = 1'($urandom_range(0, 1));
         chan_en   = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         #1;
         chk("rnd_in_ready", 32'(in_ready), 32'(m_rdy()));
         model_step();
         tick();
         exp_ov = m_held ? (4'b0001 << m_ch) : 4'b0000;
         chk("rnd_out_valid", 32'(out_valid), 32'(exp_ov));
         chk("rnd_sel",       32'(sel), 32'(m_sel));
         chk("rnd_out_data",  32'(out_data), 32'(m_data));
         chk("rnd_busy",      32'(busy), 32'(m_held));
         chk("rnd_dispatch",  32'(dispatch_cnt), 32'(m_disp % 256));
         chk("rnd_drop",      32'(drop_cnt), 32'(m_drop % 256));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
